irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped external interrupt controller.
- Collects up to NSRC peripheral interrupt requests and drives the four external interrupt lines into CP0, which appear as Cause IP[7:4].
- Provides per-source enable, edge/level trigger mode and line routing.
- Provides a claim/complete handshake so the handler learns which source fired and masks it until it is serviced.

Parameters:
- NSRC, 8: number of interrupt sources; legal range 1..16.
- SYNC_STAGES, 2: synchronizer flops per source; minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_src  in  NSRC  asynchronous peripheral requests, active-high
- bus_sel  in  1  register access strobe, one cycle per access
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  3  word offset
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- irq_out  out  4  to CP0 interrupts[7:4]; bit k drives IP[4+k]

Behaviour:
- Reset is clk and reset, synchronous, active-high. Reset clears everything to 0: sync chains, edge history, PENDING, ENABLE, MODE, ROUTE, INSERVICE, bus_rdata and irq_out.
- Reset mid-operation discards all in-service state.
- Because the sync flops reset to 0, an input already high after reset is seen as a rising edge.

Per-source state:
- Each source moves IDLE -> PEND on an event, PEND -> INSVC on a claim, and INSVC -> IDLE on a complete.
- Level mode (MODE[i]=0): pending[i] equals the synchronized input every cycle.
- Edge mode (MODE[i]=1): pending[i] is set on a synchronized 0->1 transition. It is cleared only by a claim of i.
- A new edge in the same cycle as the claim leaves pending[i]=1.
- Edges arriving while in service are latched and are not lost.

Output equation:
- irq_out[k] is registered. It is the OR over all i with ROUTE[2i+1:2i]==k of (pending[i] & ENABLE[i] & ~INSERVICE[i]).

Latency:
- irq_src sampled high at edge n gives synchronized high at edge n+SYNC_STAGES-1.
- Pending updates at edge n+SYNC_STAGES.
- irq_out asserts at edge n+SYNC_STAGES+1.

Register map (word offset):
- 0 PENDING, RO: bits[NSRC-1:0]. Writes are ignored.
- 1 ENABLE, RW.
- 2 MODE, RW: 1 = edge, 0 = level.
- 3 ROUTE, RW: 2 bits per source.
- 4 CLAIM
  - Read returns bit31=valid and bits[3:0]=id, where id is the lowest-numbered source that is enabled, pending and not in service. If there is none, the read returns 0.
  - A valid read sets INSERVICE[id] and clears edge pending[id] on that same edge.
  - A write completes the claim: it clears INSERVICE[bus_wdata[3:0]]. Ids >= NSRC are ignored. Completing a source that is not in service has no effect.
- 5 INSERVICE, RO.
- 6, 7: read 0, writes ignored, unless the optional feature is enabled.

Bus rules:
- Reads: bus_rdata updates on the edge where bus_sel=1 and bus_we=0, so it is valid in the following cycle. Otherwise bus_rdata holds its value.
- Writes take effect on the bus_sel edge.
- Unused upper bits read 0.
- RW registers are masked to NSRC bits (2*NSRC for ROUTE).
- Writing ENABLE[i]=0 suppresses irq_out contribution from the next edge but keeps pending state.
- Changing MODE does not clear pending; a level-mode source simply tracks its input.

Optional Feature:
- IRQ_SOFT_EN defined: offset 6 is SOFTSET, write-only. Writing 1 to bit i sets pending[i] for edge-mode sources; bits for level-mode sources are ignored. Reads of offset 6 return 0. The write has the same priority as a hardware edge over a simultaneous claim, so pending stays set.
- IRQ_SOFT_EN undefined: offset 6 reads 0 and writes are ignored.

Decomposition:
- Package irq_ctrl_pkg holds the register offset constants (PENDING..SOFTSET), the CLAIM valid bit index (31) and ID_W=4.
- Sub-module irq_sync, instantiated per source, contains the SYNC_STAGES-flop synchronizer plus a registered previous value. Its outputs are level and rise.

Test Plan:
1. Level path: reset, ENABLE=0x01, ROUTE=0, then raise irq_src[0] -> irq_out=0001 exactly SYNC_STAGES+1 edges after first sample; PENDING reads 0x01; dropping irq_src[0] clears irq_out with the same latency.
2. Routing and claim: MODE=0xFF, ENABLE=0xFF, ROUTE=0x0000C000 (src7 on line 3); pulse irq_src[7] and irq_src[2] for 1 cycle -> irq_out=1001; CLAIM reads 0x80000002 then 0x80000007; INSERVICE=0x84; irq_out=0000; third CLAIM reads 0x00000000.
3. Complete and re-arm: continue 2; write CLAIM=7 -> INSERVICE=0x04; pulse irq_src[7] again -> irq_out[3]=1 and CLAIM returns 0x80000007.
4. Edge during service: claim src2 (edge mode), pulse irq_src[2] while in service -> PENDING bit2=1, irq_out masked; write CLAIM=2 -> irq_out line asserts the next edge.
5. Simultaneous edge and claim: align a synchronized rise of src1 with the claim read of src1 -> read returns 0x80000001 and PENDING bit1 remains 1.
6. Reset mid-service: with INSERVICE=0x84 and irq_src[0] held high, pulse reset -> all registers read 0 and irq_out=0000; then set ENABLE=0x01 and MODE=0x01 -> the held-high input registers as an edge and PENDING bit0=1.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the external interrupt controller: register word
// offsets, CLAIM word layout and source-id width.
package irq_ctrl_pkg;

  localparam int ID_W            = 4;
  localparam int CLAIM_VALID_BIT = 31;

  localparam logic [2:0] OFF_PENDING   = 3'd0;
  localparam logic [2:0] OFF_ENABLE    = 3'd1;
  localparam logic [2:0] OFF_MODE      = 3'd2;
  localparam logic [2:0] OFF_ROUTE     = 3'd3;
  localparam logic [2:0] OFF_CLAIM     = 3'd4;
  localparam logic [2:0] OFF_INSERVICE = 3'd5;
  localparam logic [2:0] OFF_SOFTSET   = 3'd6;

endpackage

// File: rtl/irq_sync.sv
// Per-source input synchronizer with a registered copy of the synchronized
// level, so a 0->1 transition is reported as a one-cycle rise.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped external interrupt controller feeding CP0 IP[7:4], with
// per-source enable, edge/level mode, line routing and claim/complete.
// Define IRQ_SOFT_EN to add the write-only SOFTSET register at offset 6.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            bus_sel,
  input  logic            bus_we,
  input  logic [2:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic [3:0]      irq_out
);

  logic [NSRC-1:0]   level, rise;
  logic [NSRC-1:0]   pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
  logic [NSRC-1:0]   inservice_q, inservice_d;
  logic [2*NSRC-1:0] route_q, route_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        irq_q, irq_d;

  logic              rd_en, wr_en, claim_hit, claim_fire;
  logic [ID_W-1:0]   claim_id;
  logic [NSRC-1:0]   cand, claim_mask, soft_set;
  logic              unused_wdata;

  assign unused_wdata = ^bus_wdata;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_src[gi]),
      .level (level[gi]),
      .rise  (rise[gi])
    );
  end

  always_comb begin
    rd_en = bus_sel & ~bus_we;
    wr_en = bus_sel & bus_we;
    cand  = pending_q & enable_q & ~inservice_q;

    // Lowest-numbered eligible source wins the claim.
    claim_id  = '0;
    claim_hit = |cand;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) claim_id = ID_W'(i);
    end
    claim_fire = rd_en && (bus_addr == OFF_CLAIM) && claim_hit;
    claim_mask = claim_fire ? (NSRC'(1) << claim_id) : '0;

`ifdef IRQ_SOFT_EN
    soft_set = (wr_en && (bus_addr == OFF_SOFTSET)) ? (bus_wdata[NSRC-1:0] & mode_q) : '0;
`else
    soft_set = '0;
`endif

    // A new edge or soft set on the claim edge outranks the claim's clear.
    pending_d = (mode_q & ((pending_q & ~claim_mask) | rise | soft_set)) | (~mode_q & level);

    enable_d    = enable_q;
    mode_d      = mode_q;
    route_d     = route_q;
    inservice_d = inservice_q | claim_mask;
    if (wr_en) begin
      case (bus_addr)
        OFF_ENABLE: enable_d = bus_wdata[NSRC-1:0];
        OFF_MODE:   mode_d   = bus_wdata[NSRC-1:0];
        OFF_ROUTE:  route_d  = bus_wdata[2*NSRC-1:0];
        OFF_CLAIM: begin
          if (32'(bus_wdata[ID_W-1:0]) < NSRC)
            inservice_d = inservice_q & ~(NSRC'(1) << bus_wdata[ID_W-1:0]);
        end
        default: ;
      endcase
    end

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (bus_addr)
        OFF_PENDING:   rdata_d = 32'(pending_q);
        OFF_ENABLE:    rdata_d = 32'(enable_q);
        OFF_MODE:      rdata_d = 32'(mode_q);
        OFF_ROUTE:     rdata_d = 32'(route_q);
        OFF_CLAIM: begin
          rdata_d[CLAIM_VALID_BIT] = claim_hit;
          rdata_d[ID_W-1:0]        = claim_id;
        end
        OFF_INSERVICE: rdata_d = 32'(inservice_q);
        default:       rdata_d = '0;
      endcase
    end

    irq_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (route_q[2*i +: 2] == 2'(k)) irq_d[k] = irq_d[k] | cand[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      route_q     <= '0;
      inservice_q <= '0;
      rdata_q     <= '0;
      irq_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      route_q     <= route_d;
      inservice_q <= inservice_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq_out   = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table for the multi-cycle
// scenarios, then random traffic checked against a delay-line reference model.
module tb_irq_controller;
  import irq_ctrl_pkg::*;

  localparam int NSRC = 8;
  localparam int SS   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        bus_sel, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [3:0]  irq_out;

  always #5 clk = ~clk;

  irq_controller #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq_out   (irq_out)
  );

  typedef struct {
    bit        rst;
    bit        sel;
    bit        we;
    bit [2:0]  addr;
    bit [31:0] wd;
    bit [7:0]  src;
    int        ei;   // expected irq_out, negative = don't care
    bit        cr;   // check bus_rdata against er
    bit [31:0] er;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: inputs are a delay line; everything sampled at or
  // before the most recent reset is treated as zero.
  bit [7:0]  hist [0:8191];
  int        cyc = 0;
  int        floor_cyc = 0;
  bit [7:0]  m_pend, m_en, m_mode, m_insvc;
  bit [15:0] m_route;
  bit [3:0]  m_irq;
  bit [31:0] m_rdata;

  function automatic bit [7:0] samp(int k);
    if (k <= floor_cyc || k < 0) return 8'h00;
    return hist[k];
  endfunction

  task automatic model_edge(input vec_t v);
    bit [7:0] lvl, rise, cand, claimed, nxt_insvc;
    int       id;
    cyc++;
    hist[cyc] = v.src;
    if (v.rst) begin
      floor_cyc = cyc;
      m_pend = 0; m_en = 0; m_mode = 0; m_insvc = 0; m_route = 0;
      m_irq = 0; m_rdata = 0;
      return;
    end
    lvl     = samp(cyc - SS);
    rise    = lvl & ~samp(cyc - SS - 1);
    cand    = m_pend & m_en & ~m_insvc;
    claimed = 0;
    id      = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (cand[i]) id = i;

    for (int k = 0; k < 4; k++) begin
      m_irq[k] = 1'b0;
      for (int i = 0; i < NSRC; i++)
        if (int'(m_route[2*i +: 2]) == k && cand[i]) m_irq[k] = 1'b1;
    end

    if (v.sel && !v.we) begin
      case (v.addr)
        OFF_PENDING:   m_rdata = {24'b0, m_pend};
        OFF_ENABLE:    m_rdata = {24'b0, m_en};
        OFF_MODE:      m_rdata = {24'b0, m_mode};
        OFF_ROUTE:     m_rdata = {16'b0, m_route};
        OFF_INSERVICE: m_rdata = {24'b0, m_insvc};
        OFF_CLAIM: begin
          if (id >= 0) begin
            m_rdata = 32'h8000_0000 + 32'(id);
            claimed[id] = 1'b1;
          end else m_rdata = 0;
        end
        default: m_rdata = 0;
      endcase
    end

    for (int i = 0; i < NSRC; i++) begin
      if (!m_mode[i])      m_pend[i] = lvl[i];
      else if (rise[i])    m_pend[i] = 1'b1;
      else if (claimed[i]) m_pend[i] = 1'b0;
    end

    nxt_insvc = m_insvc | claimed;
    if (v.sel && v.we) begin
      case (v.addr)
        OFF_ENABLE: m_en    = v.wd[7:0];
        OFF_MODE:   m_mode  = v.wd[7:0];
        OFF_ROUTE:  m_route = v.wd[15:0];
        OFF_CLAIM:  if (v.wd[3:0] < 4'(NSRC)) nxt_insvc[v.wd[2:0]] = 1'b0;
        default: ;
      endcase
    end
    m_insvc = nxt_insvc;
  endtask

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  task automatic apply(input vec_t v, input bit from_tbl);
    reset     = v.rst;
    bus_sel   = v.sel;
    bus_we    = v.we;
    bus_addr  = v.addr;
    bus_wdata = v.wd;
    irq_src   = v.src;
    @(posedge clk);
    model_edge(v);
    #1;
    chk("irq_out_model", {28'b0, irq_out}, {28'b0, m_irq});
    if (v.sel && !v.we && !v.rst) chk("rdata_model", bus_rdata, m_rdata);
    if (from_tbl) begin
      if (v.ei >= 0) chk("irq_out_vec", {28'b0, irq_out}, 32'(v.ei));
      if (v.cr)      chk("rdata_vec", bus_rdata, v.er);
    end
  endtask

  function automatic vec_t mk(bit rst, bit sel, bit we, bit [2:0] a, bit [31:0] wd,
                              bit [7:0] s, int ei, bit cr, bit [31:0] er);
    vec_t v;
    v.rst = rst; v.sel = sel; v.we = we; v.addr = a; v.wd = wd;
    v.src = s; v.ei = ei; v.cr = cr; v.er = er;
    return v;
  endfunction
  function automatic vec_t v_idle(bit [7:0] s, int ei);
    return mk(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, s, ei, 1'b0, 32'd0);
  endfunction
  function automatic vec_t v_wr(bit [2:0] a, bit [31:0] d, bit [7:0] s, int ei);
    return mk(1'b0, 1'b1, 1'b1, a, d, s, ei, 1'b0, 32'd0);
  endfunction
  function automatic vec_t v_rd(bit [2:0] a, bit [31:0] e, bit [7:0] s, int ei);
    return mk(1'b0, 1'b1, 1'b0, a, 32'd0, s, ei, 1'b1, e);
  endfunction
  function automatic vec_t v_rst(bit [7:0] s);
    return mk(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, s, 0, 1'b1, 32'd0);
  endfunction

  initial begin
    vec_t     v;
    bit [7:0] src;
    reset = 1'b1; bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; irq_src = 0;

    // Level path: irq_out follows irq_src[0] with SS+1 edges of latency.
    tbl.push_back(v_rst(8'h00));
    tbl.push_back(v_rd(OFF_PENDING, 32'h0, 8'h00, 0));
    tbl.push_back(v_wr(OFF_ENABLE, 32'h1, 8'h00, 0));
    tbl.push_back(v_wr(OFF_ROUTE, 32'h0, 8'h00, 0));
    tbl.push_back(v_idle(8'h01, 0));
    tbl.push_back(v_idle(8'h01, 0));
    tbl.push_back(v_idle(8'h01, 0));
    tbl.push_back(v_idle(8'h01, 1));
    tbl.push_back(v_rd(OFF_PENDING, 32'h1, 8'h01, 1));
    tbl.push_back(v_idle(8'h00, 1));
    tbl.push_back(v_idle(8'h00, 1));
    tbl.push_back(v_idle(8'h00, 1));
    tbl.push_back(v_idle(8'h00, 0));
    // Routing and claim order.
    tbl.push_back(v_wr(OFF_MODE, 32'hFF, 8'h00, 0));
    tbl.push_back(v_wr(OFF_ENABLE, 32'hFF, 8'h00, 0));
    tbl.push_back(v_wr(OFF_ROUTE, 32'h0000_C000, 8'h00, 0));
    tbl.push_back(v_idle(8'h84, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h8000_0002, 8'h00, 9));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h8000_0007, 8'h00, 8));
    tbl.push_back(v_rd(OFF_INSERVICE, 32'h84, 8'h00, 0));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h0, 8'h00, 0));
    // Complete and re-arm source 7.
    tbl.push_back(v_wr(OFF_CLAIM, 32'h7, 8'h00, 0));
    tbl.push_back(v_rd(OFF_INSERVICE, 32'h04, 8'h00, 0));
    tbl.push_back(v_idle(8'h80, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h00, 8));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h8000_0007, 8'h00, 8));
    tbl.push_back(v_idle(8'h00, 0));
    // Edge on source 2 while in service is latched but masked.
    tbl.push_back(v_idle(8'h04, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_rd(OFF_PENDING, 32'h04, 8'h00, 0));
    tbl.push_back(v_wr(OFF_CLAIM, 32'h2, 8'h00, 0));
    tbl.push_back(v_idle(8'h00, 1));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h8000_0002, 8'h00, 1));
    // Second rise of source 1 lands on its claim edge.
    tbl.push_back(v_idle(8'h02, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h00, 0));
    tbl.push_back(v_idle(8'h02, 1));
    tbl.push_back(v_idle(8'h00, 1));
    tbl.push_back(v_rd(OFF_CLAIM, 32'h8000_0001, 8'h00, 1));
    tbl.push_back(v_rd(OFF_PENDING, 32'h02, 8'h00, 0));
    // Reset mid-service with source 0 held high.
    tbl.push_back(v_wr(OFF_CLAIM, 32'h1, 8'h00, 0));
    tbl.push_back(v_rd(OFF_INSERVICE, 32'h84, 8'h00, 1));
    tbl.push_back(v_idle(8'h01, 1));
    tbl.push_back(v_rst(8'h01));
    tbl.push_back(v_rd(OFF_PENDING, 32'h0, 8'h01, 0));
    tbl.push_back(v_rd(OFF_ROUTE, 32'h0, 8'h01, 0));
    tbl.push_back(v_rd(OFF_INSERVICE, 32'h0, 8'h01, 0));
    tbl.push_back(v_wr(OFF_ENABLE, 32'h1, 8'h01, 0));
    tbl.push_back(v_wr(OFF_MODE, 32'h1, 8'h01, 1));
    tbl.push_back(v_rd(OFF_PENDING, 32'h1, 8'h01, 1));
    tbl.push_back(v_rd(OFF_MODE, 32'h1, 8'h01, 1));
    tbl.push_back(v_rd(3'd7, 32'h0, 8'h01, 1));
    tbl.push_back(v_wr(OFF_PENDING, 32'hFF, 8'h01, 1));
    tbl.push_back(v_rd(OFF_PENDING, 32'h1, 8'h01, 1));

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    // Random traffic: sparse input toggles, mixed register accesses.
    src = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      src    = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      v.rst  = ($urandom_range(0, 599) == 0);
      v.sel  = 1'($urandom_range(0, 1));
      v.we   = ($urandom_range(0, 2) == 0);
      v.addr = 3'($urandom_range(0, 7));
      v.wd   = $urandom;
      v.src  = src;
      v.ei   = -1;
      v.cr   = 1'b0;
      v.er   = 32'd0;
      apply(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
